// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared 32-bit memory port (0 = fetch, 1 = data).
// Serialises one transaction at a time and aborts any that hangs past TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int          PRIO_MODE = 0,
  parameter logic [15:0] TIMEOUT   = 16'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        we0,
  input  logic        req1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  input  logic        we1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

  state_t      state_reg, state_next;
  logic        sel_reg, sel_next;
  logic        last_reg, last_next;
  logic [15:0] cnt_reg, cnt_next;

  logic busy;
  logic timeout_hit;
  logic finish;
  logic pick1;

  assign busy        = (state_reg != IDLE);
  // A real ack in the final watchdog cycle takes precedence over the abort.
  assign timeout_hit = busy && (TIMEOUT != 16'd0) && !mem_ack &&
                       (cnt_reg == TIMEOUT - 16'd1);
  assign finish      = busy && (mem_ack || timeout_hit);
  // Tie-break: data always wins in fixed mode, otherwise whoever was not served last.
  assign pick1       = (PRIO_MODE != 0) || !last_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sel_reg   <= 1'b0;
      last_reg  <= 1'b1;
      cnt_reg   <= 16'd0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = 16'd0;
        if (req0 && req1) begin
          state_next = pick1 ? BUSY1 : BUSY0;
          sel_next   = pick1;
        end else if (req0) begin
          state_next = BUSY0;
          sel_next   = 1'b0;
        end else if (req1) begin
          state_next = BUSY1;
          sel_next   = 1'b1;
        end
      end
      BUSY0, BUSY1: begin
        if (finish) begin
          state_next = IDLE;
          last_next  = (state_reg == BUSY1);
          cnt_next   = 16'd0;
        end else if (cnt_reg != 16'hFFFF) begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign gnt0      = (state_reg == BUSY0);
  assign gnt1      = (state_reg == BUSY1);
  assign mem_req   = busy;
  assign sel       = sel_reg;
  assign done0     = gnt0 && finish;
  assign done1     = gnt1 && finish;
  assign err       = timeout_hit;
  assign rdata     = mem_rdata;
  assign mem_addr  = sel_reg ? addr1 : addr0;
  assign mem_wdata = sel_reg ? wdata1 : wdata0;
  assign mem_we    = busy && (sel_reg ? we1 : we0);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter sharing a single 32-bit memory port between instruction fetch (requester 0) and data access (requester 1) in the multi-cycle CPU datapath.
- Owns the select line of the 32-bit 2:1 address/write-data multiplexers in front of memory. Sequences one transaction at a time with a req/ack handshake.
- Provides a watchdog so a hung memory cannot stall the core forever.

Parameters:
- PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority, requester 1 (data) always wins ties.
- TIMEOUT, 16'd64, number of BUSY cycles without mem_ack before the transaction is aborted; 0 disables the watchdog.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- req0  input  1  requester 0 transaction request; held high until done0
- addr0  input  32  requester 0 address; stable while req0 high
- wdata0  input  32  requester 0 write data
- we0  input  1  requester 0 write enable
- req1, addr1, wdata1, we1  input  1/32/32/1  same as above, for requester 1
- gnt0, gnt1  output  1  one-hot grant; requester owns the port
- done0, done1  output  1  transaction complete (combinational: gnt_x & (mem_ack | timeout))
- err  output  1  high together with done_x when completion was by timeout
- rdata  output  32  mem_rdata passthrough; valid when done_x is high and err is low
- sel  output  1  mux select: 0 = requester 0, 1 = requester 1
- mem_req  output  1  high in any BUSY state
- mem_addr, mem_wdata  output  32  sel ? addr1/wdata1 : addr0/wdata0
- mem_we  output  1  gated by mem_req (0 in IDLE)
- mem_ack  input  1  memory completes the transaction this cycle
- mem_rdata  input  32  memory read data

Behaviour:
- Reset values:
  - state = IDLE; gnt0, gnt1, mem_req, mem_we, done0, done1, err = 0.
  - sel = 0; last = 1, so requester 0 wins the first tie; watchdog counter = 0.
  - rst overrides everything, including mid-transaction: the port is released immediately and an outstanding transaction is dropped with no done.
- States: IDLE, BUSY0, BUSY1. sel, gnt and mem_req are registered and derive from the state.
- IDLE:
  - Only req0 high -> BUSY0. Only req1 high -> BUSY1. Neither -> stay in IDLE.
  - Both high, PRIO_MODE=1 -> BUSY1.
  - Both high, PRIO_MODE=0 -> grant the requester that is not `last`.
- BUSYx:
  - mem_ack=1 -> done_x=1 this cycle, IDLE next cycle, last <= x, counter <= 0.
  - mem_ack=0 and TIMEOUT!=0 and counter == TIMEOUT-1 -> done_x=1 and err=1 this cycle, IDLE next cycle, last <= x, counter <= 0.
  - Otherwise stay and increment the counter; the counter saturates and never wraps.
- Latency:
  - req rises in cycle n (sampled at the n/n+1 edge) -> gnt and mem_req high in cycle n+1.
  - Earliest done is in cycle n+1, if mem_ack is high that cycle.
  - Each transaction costs at least one IDLE bubble cycle; the same requester's back-to-back throughput is therefore one transaction per 2 cycles.
- Requester contract:
  - Drop req at the edge ending the done cycle, or keep it high to request again.
  - If req drops mid-BUSY, the arbiter still waits for mem_ack/timeout and pulses done; the memory transaction is never aborted by a requester.
- mem_ack in IDLE is ignored and causes no done.
- Invariants: gnt0 & gnt1 is never 1; done_x implies gnt_x; sel changes only on the IDLE->BUSY edge.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with req0=req1=1 -> all outputs 0 and sel=0 during reset. First cycle after release: still IDLE. Next cycle: gnt0=1 (last=1 at reset).
- Single read: req1=1, addr1=32'h0000_0040, we1=0. mem_ack high 3 cycles after gnt1 with mem_rdata=32'hDEAD_BEEF -> sel=1, mem_addr=32'h40, mem_we=0; done1=1 with rdata=32'hDEADBEEF, err=0; IDLE next cycle.
- Round-robin contention, PRIO_MODE=0: req0 and req1 held high, mem_ack=1 every BUSY cycle -> grants alternate 0,1,0,1 with one IDLE cycle between each. With PRIO_MODE=1 the same stimulus gives 1,1,1.
- Write path: req0=1, we0=1, addr0=32'h100, wdata0=32'h1234_5678 -> mem_we=1, mem_wdata=32'h12345678 only while BUSY0; mem_we=0 in IDLE.
- Timeout with TIMEOUT=4: req0=1, mem_ack never asserted -> done0=1 and err=1 in the 4th BUSY0 cycle, IDLE next cycle. A pending req1 is granted after that.
- Reset mid-operation: rst=1 in the 2nd BUSY1 cycle -> the next cycle shows IDLE with gnt1=0, mem_req=0 and no done1 pulse. A mem_ack arriving afterwards while in IDLE produces no done.
